// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Holds the default geometry (data width, register count, read ports) and
// the address/data word typedefs for that default geometry.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Tracks which registers have an outstanding writeback, refuses a second
// claim on a busy register (WAW), and publishes a registered busy count.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rs_addr / rs_busy     per read port: source address in, pending-write flag out
//   we, rd_addr           writeback (clears busy)
//   issue_en, issue_rd    destination claim (sets busy)
//   issue_stall           claim refused
//   flush                 drop all claims
//   busy_cnt              popcount of busy bits, registered
module rf_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD-1:0][AW-1:0]  rs_addr,
  output logic [NRD-1:0]          rs_busy,
  input  logic                    we,
  input  logic [AW-1:0]           rd_addr,
  input  logic                    issue_en,
  input  logic [AW-1:0]           issue_rd,
  output logic                    issue_stall,
  input  logic                    flush,
  output logic [AW:0]             busy_cnt
);

  logic [NREG-1:0] busy, busy_nxt;
  logic [AW:0]     cnt_nxt;

  // A writeback landing on the same register this cycle resolves the hazard,
  // so the claim is accepted rather than stalled.
  assign issue_stall = issue_en && (issue_rd != '0) && busy[issue_rd] &&
                       !(we && (rd_addr == issue_rd));

  for (genvar i = 0; i < NRD; i++) begin : g_rs
    assign rs_busy[i] = (rs_addr[i] != '0) && busy[rs_addr[i]] &&
                        !(we && (rd_addr == rs_addr[i]));
  end

  // Writeback clear is applied before the issue set so a same-cycle claim on
  // the written register ends up busy; flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[rd_addr] = 1'b0;
    if (flush) busy_nxt = '0;
    else if (issue_en && (issue_rd != '0) && !issue_stall) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int r = 1; r < NREG; r++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with writeback bypass and a busy-bit scoreboard.
// x0 is hardwired to zero. Reads are combinational; a same-cycle writeback to
// a read address is forwarded onto that port. The debug port sees storage only.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   rs_addr / rs_data / rs_busy     NRD read ports
//   we, rd_addr, wdata              writeback
//   issue_en, issue_rd, issue_stall destination claim and WAW refusal
//   flush                           drop all pending claims
//   busy_cnt                        number of busy registers (registered)
//   dbg_addr / dbg_data             unbypassed debug read
module regfile_sb import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rs_addr,
  output logic [NRD-1:0][XLEN-1:0] rs_data,
  output logic [NRD-1:0]           rs_busy,
  input  logic                     we,
  input  logic [AW-1:0]            rd_addr,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_rd,
  output logic                     issue_stall,
  input  logic                     flush,
  output logic [AW:0]              busy_cnt,
  input  logic [AW-1:0]            dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);

  logic [NREG-1:0][XLEN-1:0] mem;
  logic                      wr_en;

  assign wr_en = we && (rd_addr != '0);

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (wr_en) mem[rd_addr] <= wdata;
  end

  // Read data is forced to zero during reset so the bypass path cannot
  // leak wdata while the array is being cleared.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    always_comb begin
      rs_data[i] = mem[rs_addr[i]];
      if (!rst_n || (rs_addr[i] == '0)) rs_data[i] = '0;
      else if (wr_en && (rd_addr == rs_addr[i])) rs_data[i] = wdata;
    end
  end

  assign dbg_data = rst_n ? mem[dbg_addr] : '0;

  rf_scoreboard #(.NREG(NREG), .NRD(NRD), .AW(AW)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs_addr     (rs_addr),
    .rs_busy     (rs_busy),
    .we          (we),
    .rd_addr     (rd_addr),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .flush       (flush),
    .busy_cnt    (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, hand-written
// multi-cycle sequences (fill/flush, reset mid-flight) and a randomized
// phase checked against an array-based reference model.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NRD-1:0][AW-1:0]   rs_addr;
  logic [NRD-1:0][XLEN-1:0] rs_data;
  logic [NRD-1:0]           rs_busy;
  logic                     we;
  logic [AW-1:0]            rd_addr;
  logic [XLEN-1:0]          wdata;
  logic                     issue_en;
  logic [AW-1:0]            issue_rd;
  logic                     issue_stall;
  logic                     flush;
  logic [AW:0]              busy_cnt;
  logic [AW-1:0]            dbg_addr;
  logic [XLEN-1:0]          dbg_data;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .we(we), .rd_addr(rd_addr), .wdata(wdata), .issue_en(issue_en), .issue_rd(issue_rd),
    .issue_stall(issue_stall), .flush(flush), .busy_cnt(busy_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        ie;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  ra0, ra1, dbg;
  } drv_t;

  typedef struct {
    drv_t        d;
    logic [31:0] d0, d1, dbgv;
    logic [1:0]  bsy;
    logic        stall;
    int          cnt;
  } vec_t;

  // Reference model: architectural register values and the set of busy regs.
  logic [31:0] mreg [NREG];
  bit          mbusy[NREG];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic drv_t dv(int w, int rd, logic [31:0] wd, int ie, int ird, int fl,
                              int ra0, int ra1, int dbg);
    drv_t d;
    d.we = w[0]; d.rd = rd[4:0]; d.wdata = wd; d.ie = ie[0]; d.ird = ird[4:0];
    d.fl = fl[0]; d.ra0 = ra0[4:0]; d.ra1 = ra1[4:0]; d.dbg = dbg[4:0];
    return d;
  endfunction

  function automatic vec_t mk(drv_t d, logic [31:0] d0, logic [31:0] d1, logic [31:0] dbgv,
                              int bsy, int stall, int cnt);
    vec_t v;
    v.d = d; v.d0 = d0; v.d1 = d1; v.dbgv = dbgv;
    v.bsy = bsy[1:0]; v.stall = stall[0]; v.cnt = cnt;
    return v;
  endfunction

  function automatic int mcount();
    int n = 0;
    foreach (mbusy[r]) n += int'(mbusy[r]);
    return n;
  endfunction

  function automatic logic [31:0] m_read(drv_t d, logic [4:0] a);
    if (a == 0) return 32'h0;
    if (d.we && d.rd == a) return d.wdata;
    return mreg[a];
  endfunction

  function automatic logic m_busy(drv_t d, logic [4:0] a);
    return (a != 0) && mbusy[a] && !(d.we && d.rd == a);
  endfunction

  function automatic logic m_stall(drv_t d);
    return d.ie && (d.ird != 0) && mbusy[d.ird] && !(d.we && d.rd == d.ird);
  endfunction

  task automatic m_reset();
    foreach (mreg[r]) begin mreg[r] = 32'h0; mbusy[r] = 1'b0; end
  endtask

  task automatic apply(input drv_t d);
    we = d.we; rd_addr = d.rd; wdata = d.wdata; issue_en = d.ie; issue_rd = d.ird;
    flush = d.fl; rs_addr[0] = d.ra0; rs_addr[1] = d.ra1; dbg_addr = d.dbg;
  endtask

  // One cycle: drive at edge+1, compare combinational outputs mid-cycle,
  // advance the model at the edge, compare the registered count after it.
  task automatic step(input drv_t d, output logic [31:0] o_d0, output logic [31:0] o_d1,
                      output logic [31:0] o_dbg, output logic [1:0] o_bsy, output logic o_stall);
    logic st;
    apply(d);
    #4;
    o_d0 = rs_data[0]; o_d1 = rs_data[1]; o_dbg = dbg_data; o_bsy = rs_busy; o_stall = issue_stall;
    st = m_stall(d);
    chk("m_rs_data0", rs_data[0], m_read(d, d.ra0));
    chk("m_rs_data1", rs_data[1], m_read(d, d.ra1));
    chk("m_rs_busy0", 32'(rs_busy[0]), 32'(m_busy(d, d.ra0)));
    chk("m_rs_busy1", 32'(rs_busy[1]), 32'(m_busy(d, d.ra1)));
    chk("m_stall", 32'(issue_stall), 32'(st));
    chk("m_dbg", dbg_data, mreg[d.dbg]);
    @(posedge clk);
    if (d.we && d.rd != 0) begin mreg[d.rd] = d.wdata; mbusy[d.rd] = 1'b0; end
    if (d.fl) foreach (mbusy[r]) mbusy[r] = 1'b0;
    else if (d.ie && d.ird != 0 && !st) mbusy[d.ird] = 1'b1;
    #1;
    chk("m_busy_cnt", 32'(busy_cnt), mcount());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rs_data0"}, rs_data[0], 32'h0);
    chk({tag, "_rs_data1"}, rs_data[1], 32'h0);
    chk({tag, "_rs_busy"}, 32'(rs_busy), 32'h0);
    chk({tag, "_stall"}, 32'(issue_stall), 32'h0);
    chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'h0);
    chk({tag, "_dbg"}, dbg_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vt[13];
    logic [31:0] o_d0, o_d1, o_dbg;
    logic [1:0]  o_bsy;
    logic        o_st;
    drv_t        d;

    vt[0]  = mk(dv(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 5), 32'hDEADBEEF, 0, 0, 0, 0, 0);
    vt[1]  = mk(dv(0, 0, 0, 0, 0, 0, 5, 0, 5), 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0);
    vt[2]  = mk(dv(0, 0, 0, 1, 7, 0, 5, 7, 7), 32'hDEADBEEF, 0, 0, 0, 0, 1);
    vt[3]  = mk(dv(1, 7, 32'h12345678, 0, 0, 0, 5, 7, 7), 32'hDEADBEEF, 32'h12345678, 0, 0, 0, 0);
    vt[4]  = mk(dv(0, 0, 0, 0, 0, 0, 5, 7, 7), 32'hDEADBEEF, 32'h12345678, 32'h12345678, 0, 0, 0);
    vt[5]  = mk(dv(0, 0, 0, 1, 3, 0, 3, 7, 3), 0, 32'h12345678, 0, 0, 0, 1);
    vt[6]  = mk(dv(0, 0, 0, 1, 3, 0, 3, 7, 3), 0, 32'h12345678, 0, 1, 1, 1);
    vt[7]  = mk(dv(1, 3, 32'h33, 0, 0, 0, 3, 3, 3), 32'h33, 32'h33, 0, 0, 0, 0);
    vt[8]  = mk(dv(0, 0, 0, 1, 4, 0, 4, 3, 4), 0, 32'h33, 0, 0, 0, 1);
    vt[9]  = mk(dv(1, 4, 32'h44, 1, 4, 0, 4, 0, 4), 32'h44, 0, 0, 0, 0, 1);
    vt[10] = mk(dv(0, 0, 0, 0, 0, 0, 4, 3, 4), 32'h44, 32'h33, 32'h44, 1, 0, 1);
    vt[11] = mk(dv(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1);
    vt[12] = mk(dv(0, 0, 0, 0, 0, 0, 0, 4, 0), 0, 32'h44, 0, 2, 0, 1);

    // Reset with live-looking inputs: outputs must stay zero, bypass included.
    m_reset();
    rst_n = 1'b0;
    apply(dv(1, 5, 32'hCAFEF00D, 1, 5, 0, 5, 5, 5));
    #1;
    check_reset_outputs("rst");
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("rst_hold");
    apply(dv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[k]) begin
      step(vt[k].d, o_d0, o_d1, o_dbg, o_bsy, o_st);
      chk($sformatf("vec%0d_d0", k), o_d0, vt[k].d0);
      chk($sformatf("vec%0d_d1", k), o_d1, vt[k].d1);
      chk($sformatf("vec%0d_dbg", k), o_dbg, vt[k].dbgv);
      chk($sformatf("vec%0d_busy", k), 32'(o_bsy), 32'(vt[k].bsy));
      chk($sformatf("vec%0d_stall", k), 32'(o_st), 32'(vt[k].stall));
      chk($sformatf("vec%0d_cnt", k), 32'(busy_cnt), 32'(vt[k].cnt));
    end

    // Claim every register, then flush with a competing claim.
    for (int r = 1; r < NREG; r++) step(dv(0, 0, 0, 1, r, 0, r, 0, 0), o_d0, o_d1, o_dbg, o_bsy, o_st);
    chk("fill_cnt", 32'(busy_cnt), 32'd31);
    step(dv(0, 0, 0, 1, 9, 1, 9, 4, 9), o_d0, o_d1, o_dbg, o_bsy, o_st);
    chk("flush_cnt", 32'(busy_cnt), 32'd0);
    for (int r = 1; r < NREG; r++) begin
      step(dv(0, 0, 0, 0, 0, 0, r, NREG - r, 0), o_d0, o_d1, o_dbg, o_bsy, o_st);
      chk($sformatf("post_flush_busy%0d", r), 32'(o_bsy), 32'd0);
    end

    // Reset asserted mid-sequence with a claim and write in flight.
    step(dv(0, 0, 0, 1, 10, 0, 0, 0, 0), o_d0, o_d1, o_dbg, o_bsy, o_st);
    step(dv(1, 5, 32'h5555AAAA, 1, 11, 0, 5, 10, 5), o_d0, o_d1, o_dbg, o_bsy, o_st);
    apply(dv(1, 5, 32'h0BADF00D, 1, 10, 0, 5, 10, 5));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_reset();
    apply(dv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(dv(0, 0, 0, 1, 10, 0, 5, 10, 5), o_d0, o_d1, o_dbg, o_bsy, o_st);
    chk("after_rst_cnt", 32'(busy_cnt), 32'd1);
    chk("after_rst_x5", o_d0, 32'h0);

    // Randomized traffic, biased to a few low registers to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      int a[5];
      foreach (a[j]) a[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      d = dv($urandom_range(0, 1), a[0], $urandom, $urandom_range(0, 1), a[1],
             ($urandom_range(0, 15) == 0) ? 1 : 0, a[2], a[3], a[4]);
      step(d, o_d0, o_d1, o_dbg, o_bsy, o_st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
